// File: rtl/queue_if.sv
// Handshake/data bundle for the queue: producer/consumer side (master) and
// storage side (slave).
interface queue_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 10
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic             we;
  logic [WIDTH-1:0] in;
  logic             re;
  logic [WIDTH-1:0] out;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             unf;

  modport master (
    output we, in, re,
    input  out, empty, full, count, ovf, unf
  );

  modport slave (
    input  we, in, re,
    output out, empty, full, count, ovf, unf
  );
endinterface

// File: rtl/queue.sv
// Synchronous first-word-fall-through queue of DEPTH x WIDTH registers.
// DEPTH need not be a power of two, so both pointers wrap by explicit compare.
// A pop is evaluated first, which lets a push into a full queue succeed when
// the head leaves in the same cycle.
module queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 10
) (
  input  logic   clk,
  input  logic   rst,
  queue_if.slave bus_if
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rp_q, rp_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push_s, pop_s;

  // Acceptance, next pointers, occupancy, flags and rejection pulses.
  always_comb begin
    pop_s  = bus_if.re & ~empty_q;
    push_s = bus_if.we & (~full_q | pop_s);

    rp_d = rp_q;
    if (pop_s) begin
      if (rp_q == PW'(DEPTH - 1)) begin
        rp_d = '0;
      end else begin
        rp_d = rp_q + PW'(1);
      end
    end else begin
      rp_d = rp_q;
    end

    wp_d = wp_q;
    if (push_s) begin
      if (wp_q == PW'(DEPTH - 1)) begin
        wp_d = '0;
      end else begin
        wp_d = wp_q + PW'(1);
      end
    end else begin
      wp_d = wp_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    empty_d = (count_d == CW'(0));
    full_d  = (count_d == CW'(DEPTH));
    ovf_d   = bus_if.we & ~push_s;
    unf_d   = bus_if.re & ~pop_s;
  end

  // State update; reset clears storage so the head reads 0 afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wp_q] <= bus_if.in;
      end
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus_if.out   = mem_q[rp_q];
  assign bus_if.empty = empty_q;
  assign bus_if.full  = full_q;
  assign bus_if.count = count_q;
  assign bus_if.ovf   = ovf_q;
  assign bus_if.unf   = unf_q;
endmodule

// File: tb/tb_queue.sv
// Scoreboard bench for queue: the driver updates a queue-based model and
// pushes the expected post-edge state; a monitor pops and compares each cycle.
module tb_queue;
  localparam int WIDTH = 16;
  localparam int DEPTH = 10;

  typedef struct packed {
    logic [7:0]       cnt;
    logic             ovf;
    logic             unf;
    logic             chk_out;
    logic [WIDTH-1:0] out;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   fails = 0;

  logic [WIDTH-1:0] mdl [$];
  exp_t             exp_q [$];

  queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model decides what the queue must look like after the edge.
  task automatic step(input logic r, input logic w, input logic rd, input logic [WIDTH-1:0] d);
    exp_t e;
    logic pop_ok, push_ok;
    logic [WIDTH-1:0] tmp;
    @(negedge clk);
    rst    = r;
    bus.we = w;
    bus.re = rd;
    bus.in = d;
    e = '0;
    if (r) begin
      mdl.delete();
      e.chk_out = 1'b1;
      e.out     = '0;
    end else begin
      pop_ok  = rd && (mdl.size() > 0);
      push_ok = w && ((mdl.size() < DEPTH) || pop_ok);
      e.ovf   = w && !push_ok;
      e.unf   = rd && !pop_ok;
      if (pop_ok) tmp = mdl.pop_front();
      if (push_ok) mdl.push_back(d);
      e.chk_out = (mdl.size() > 0);
      e.out     = e.chk_out ? mdl[0] : '0;
    end
    e.cnt = 8'(mdl.size());
    exp_q.push_back(e);
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    step(1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, 1'b1, 16'h0000);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  // Monitor: compare the presented state against the oldest pending expectation.
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("count", 32'(bus.count), 32'(e.cnt));
      chk("empty", 32'(bus.empty), 32'(e.cnt == 8'd0));
      chk("full",  32'(bus.full),  32'(e.cnt == 8'(DEPTH)));
      chk("ovf",   32'(bus.ovf),   32'(e.ovf));
      chk("unf",   32'(bus.unf),   32'(e.unf));
      if (e.chk_out) chk("out", 32'(bus.out), 32'(e.out));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.we = 1'b0;
    bus.re = 1'b0;
    bus.in = '0;

    step(1'b1, 1'b0, 1'b0, 16'h0000);
    idle();

    // Fill and drain in order.
    for (int i = 1; i <= DEPTH; i++) push(16'(i));
    for (int i = 0; i < DEPTH; i++) pop();

    // Wrap: move both pointers to 7, then push past the end of the array.
    for (int i = 0; i < 7; i++) push(16'(i + 100));
    for (int i = 0; i < 7; i++) pop();
    for (int i = 0; i < 10; i++) push(16'(16'hA0 + i));
    for (int i = 0; i < 10; i++) pop();

    // Full with simultaneous push/pop, then drain (last out is 0x55).
    for (int i = 1; i <= DEPTH; i++) push(16'(i));
    step(1'b0, 1'b1, 1'b1, 16'h0055);
    // Push into full without pop is rejected.
    push(16'h0077);
    idle();
    for (int i = 0; i < DEPTH; i++) pop();
    // Pop from empty is rejected.
    pop();
    idle();

    // Empty with simultaneous push/pop.
    step(1'b0, 1'b1, 1'b1, 16'h003C);
    idle();
    pop();

    // Reset mid-operation with both enables high.
    for (int i = 0; i < 5; i++) push(16'(16'h0200 + i));
    step(1'b1, 1'b1, 1'b1, 16'h1234);
    idle();

    // Randomized traffic: write-heavy, read-heavy and balanced phases.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 200; i++) begin
        int unsigned wp, rdp;
        wp  = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
        rdp = 100 - wp;
        step(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 99) < wp),
             ($urandom_range(0, 99) < rdp),
             16'($urandom));
      end
    end

    idle();
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
